// File: rtl/uart_fifo_pkg.sv
// Shared types for the UART / debug-transport FIFOs.
// Status flags bundle and a pointer-width helper.
package uart_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic half;
        logic afull;
        logic aempty;
    } fifo_status_t;

    // Bits needed to hold a count of 0..depth inclusive.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/level_fifo_if.sv
// Request/response bundle of level_fifo.
// master drives requests, slave is the FIFO.
interface level_fifo_if #(
    parameter int DBITS = 8,
    parameter int ABITS = 2
);
    logic             FLUSH_I;
    logic             CLR_ERR_I;
    logic             WE_I;
    logic [DBITS-1:0] W_DATA_I;
    logic             RE_I;
    logic [DBITS-1:0] R_DATA_O;
    logic             FULL_O;
    logic             EMPTY_O;
    logic             HALF_FULL_O;
    logic             ALMOST_FULL_O;
    logic             ALMOST_EMPTY_O;
    logic [ABITS:0]   COUNT_O;
    logic             OVERFLOW_O;
    logic             UNDERFLOW_O;

    modport master (
        output FLUSH_I, CLR_ERR_I, WE_I, W_DATA_I, RE_I,
        input  R_DATA_O, FULL_O, EMPTY_O, HALF_FULL_O,
        input  ALMOST_FULL_O, ALMOST_EMPTY_O, COUNT_O,
        input  OVERFLOW_O, UNDERFLOW_O
    );

    modport slave (
        input  FLUSH_I, CLR_ERR_I, WE_I, W_DATA_I, RE_I,
        output R_DATA_O, FULL_O, EMPTY_O, HALF_FULL_O,
        output ALMOST_FULL_O, ALMOST_EMPTY_O, COUNT_O,
        output OVERFLOW_O, UNDERFLOW_O
    );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DBITS storage for level_fifo.
// Registered write port, asynchronous read port.
module fifo_ram #(
    parameter int DBITS = 8,
    parameter int ABITS = 2
) (
    input  logic             CLK_I,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [DBITS-1:0] rdata
);
    localparam int DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem [DEPTH];

    // Store the accepted word; contents are deliberately not reset.
    always_ff @(posedge CLK_I) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/level_fifo.sv
// FWFT synchronous FIFO with occupancy count, level flags,
// synchronous flush and sticky overflow/underflow flags.
module level_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DBITS    = 8,
    parameter int ABITS    = 2,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    level_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ABITS;
    localparam int PW    = cnt_bits(DEPTH);

    localparam logic [PW-1:0] WRAP_C = PW'(DEPTH);
    localparam logic [PW-1:0] HALF_C = PW'(DEPTH / 2);
    localparam logic [PW-1:0] AF_C   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C   = PW'(AE_LEVEL);

    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_cfg_err
        $error("level_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic             ovf_q;
    logic             unf_q;
    logic             run;
    logic             rd_acc;
    logic             wr_acc;
    logic             ovf_set;
    logic             unf_set;
    logic [DBITS-1:0] ram_rdata;
    fifo_status_t     st;

    assign count = wr_ptr - rd_ptr;

    // Decode all level flags from the registered pointers only.
    always_comb begin
        st        = '0;
        st.empty  = (wr_ptr == rd_ptr);
        st.full   = ((wr_ptr ^ rd_ptr) == WRAP_C);
        st.half   = (count >= HALF_C);
        st.afull  = (count >= AF_C);
        st.aempty = (count <= AE_C);
    end

    // A flush swallows both requests without raising any error.
    assign run     = !bus.FLUSH_I;
    assign rd_acc  = run & bus.RE_I & !st.empty;
    assign wr_acc  = run & bus.WE_I & (!st.full | rd_acc);
    assign ovf_set = run & bus.WE_I & !wr_acc;
    assign unf_set = run & bus.RE_I & !rd_acc;

    // Pointer advance, flush and sticky error bookkeeping.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (bus.FLUSH_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ovf_q <= (ovf_q & !bus.CLR_ERR_I) | ovf_set;
            unf_q <= (unf_q & !bus.CLR_ERR_I) | unf_set;
        end
    end

    fifo_ram #(
        .DBITS (DBITS),
        .ABITS (ABITS)
    ) u_ram (
        .CLK_I (CLK_I),
        .we    (wr_acc),
        .waddr (wr_ptr[ABITS-1:0]),
        .wdata (bus.W_DATA_I),
        .raddr (rd_ptr[ABITS-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.R_DATA_O       = st.empty ? '0 : ram_rdata;
    assign bus.FULL_O         = st.full;
    assign bus.EMPTY_O        = st.empty;
    assign bus.HALF_FULL_O    = st.half;
    assign bus.ALMOST_FULL_O  = st.afull;
    assign bus.ALMOST_EMPTY_O = st.aempty;
    assign bus.COUNT_O        = count;
    assign bus.OVERFLOW_O     = ovf_q;
    assign bus.UNDERFLOW_O    = unf_q;
endmodule

// File: tb/tb_level_fifo.sv
// Self-checking bench for level_fifo (DBITS=8, ABITS=2).
// Queue model compared every cycle plus directed literal checks.
module tb_level_fifo;
    localparam int DBITS = 8;
    localparam int ABITS = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    level_fifo_if #(.DBITS(DBITS), .ABITS(ABITS)) bus ();

    level_fifo #(
        .DBITS    (DBITS),
        .ABITS    (ABITS),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .CLK_I  (clk),
        .RST_NI (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: queue of stored words and the two sticky flags.
    logic [DBITS-1:0] q [$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update follows the acceptance rules directly.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else if (bus.FLUSH_I) begin
            q.delete();
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else begin
            m_unf <= (m_unf && !bus.CLR_ERR_I) || (bus.RE_I && q.size() == 0);
            m_ovf <= (m_ovf && !bus.CLR_ERR_I) ||
                     (bus.WE_I && q.size() == DEPTH && !bus.RE_I);
            if (bus.RE_I && q.size() != 0) begin
                void'(q.pop_front());
                if (bus.WE_I) q.push_back(bus.W_DATA_I);
            end else if (bus.WE_I && q.size() != DEPTH) begin
                q.push_back(bus.W_DATA_I);
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        chk("count", int'(bus.COUNT_O), q.size());
        chk("empty", int'(bus.EMPTY_O), int'(q.size() == 0));
        chk("full", int'(bus.FULL_O), int'(q.size() == DEPTH));
        chk("half", int'(bus.HALF_FULL_O), int'(q.size() >= DEPTH / 2));
        chk("afull", int'(bus.ALMOST_FULL_O), int'(q.size() >= 3));
        chk("aempty", int'(bus.ALMOST_EMPTY_O), int'(q.size() <= 1));
        chk("rdata", int'(bus.R_DATA_O), (q.size() == 0) ? 0 : int'(q[0]));
        chk("ovf", int'(bus.OVERFLOW_O), int'(m_ovf));
        chk("unf", int'(bus.UNDERFLOW_O), int'(m_unf));
    end

    // One clock of requests, applied at a falling edge.
    task automatic step(input logic we, input logic [7:0] wd,
                        input logic re, input logic fl, input logic clr);
        bus.WE_I      = we;
        bus.W_DATA_I  = wd;
        bus.RE_I      = re;
        bus.FLUSH_I   = fl;
        bus.CLR_ERR_I = clr;
        @(posedge clk);
        @(negedge clk);
        bus.WE_I      = 1'b0;
        bus.RE_I      = 1'b0;
        bus.FLUSH_I   = 1'b0;
        bus.CLR_ERR_I = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_empty"}, int'(bus.EMPTY_O), 1);
        chk({nm, "_aempty"}, int'(bus.ALMOST_EMPTY_O), 1);
        chk({nm, "_count"}, int'(bus.COUNT_O), 0);
        chk({nm, "_rdata"}, int'(bus.R_DATA_O), 0);
        chk({nm, "_full"}, int'(bus.FULL_O), 0);
        chk({nm, "_half"}, int'(bus.HALF_FULL_O), 0);
        chk({nm, "_afull"}, int'(bus.ALMOST_FULL_O), 0);
        chk({nm, "_ovf"}, int'(bus.OVERFLOW_O), 0);
        chk({nm, "_unf"}, int'(bus.UNDERFLOW_O), 0);
    endtask

    logic [7:0] wv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] dv [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

    initial begin
        bus.WE_I      = 1'b0;
        bus.W_DATA_I  = '0;
        bus.RE_I      = 1'b0;
        bus.FLUSH_I   = 1'b0;
        bus.CLR_ERR_I = 1'b0;

        // Reset values before any clock edge.
        #2;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, overflow, drain.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, wv[i], 1'b0, 1'b0, 1'b0);
            chk("fill_cnt", int'(bus.COUNT_O), i + 1);
            chk("fill_af", int'(bus.ALMOST_FULL_O), int'(i >= 2));
            chk("fill_full", int'(bus.FULL_O), int'(i == 3));
            chk("fill_half", int'(bus.HALF_FULL_O), int'(i >= 1));
        end
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", int'(bus.OVERFLOW_O), 1);
        chk("ovf_cnt", int'(bus.COUNT_O), 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain1", int'(bus.R_DATA_O), int'(wv[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain1_empty", int'(bus.EMPTY_O), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", int'(bus.OVERFLOW_O), 0);

        // Full with simultaneous read and write.
        for (int i = 0; i < 4; i++) step(1'b1, wv[i], 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        chk("rw_full_cnt", int'(bus.COUNT_O), 4);
        chk("rw_full_head", int'(bus.R_DATA_O), 8'h22);
        chk("rw_full_ovf", int'(bus.OVERFLOW_O), 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain2", int'(bus.R_DATA_O), int'(dv[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Underflow, then read+write on empty, then clear.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("unf_set", int'(bus.UNDERFLOW_O), 1);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("erw_cnt", int'(bus.COUNT_O), 1);
        chk("erw_data", int'(bus.R_DATA_O), 8'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("unf_clr", int'(bus.UNDERFLOW_O), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Write/read pairs across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk("pair_data", int'(bus.R_DATA_O), i);
            chk("pair_cnt", int'(bus.COUNT_O), 1);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Flush beats a write and raises nothing.
        for (int i = 0; i < 3; i++) step(1'b1, wv[i], 1'b0, 1'b0, 1'b0);
        chk("pre_flush_cnt", int'(bus.COUNT_O), 3);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("flush_cnt", int'(bus.COUNT_O), 0);
        chk("flush_empty", int'(bus.EMPTY_O), 1);
        chk("flush_ovf", int'(bus.OVERFLOW_O), 0);
        chk("flush_unf", int'(bus.UNDERFLOW_O), 0);

        // Asynchronous reset in the middle of a burst.
        step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        bus.WE_I     = 1'b1;
        bus.W_DATA_I = 8'h83;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        bus.WE_I = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", int'(bus.R_DATA_O), 8'h99);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
